// File: rtl/rtc_defs_pkg.sv
// rtl/rtc_defs_pkg.sv - shared RTC sequencer state and mode encodings
package rtc_defs_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } estado_t;

  localparam logic MODO_UNICO = 1'b0;
  localparam logic MODO_CONT  = 1'b1;

endpackage

// File: rtl/contador_rtc_prog.sv
// rtl/contador_rtc_prog.sv - programmable phase timer for the RTC bus-access sequencer
module contador_rtc_prog
  import rtc_defs_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inicio,
  input  logic             parar,
  input  logic             pausa,
  input  logic             modo,
  input  logic [WIDTH-1:0] tiempo,
  output logic [WIDTH-1:0] cuenta,
  output logic             fin,
  output logic             ocupado
);

  estado_t          r_estado;
  logic [WIDTH-1:0] r_cuenta;
  logic [WIDTH-1:0] r_periodo;
  logic             r_modo;
  logic             r_fin;

  estado_t          w_estado_nxt;
  logic [WIDTH-1:0] w_cuenta_nxt;
  logic             w_fin_nxt;
  logic             w_cargar;
  logic             w_terminal;

  // periodo is never 0 while running, so periodo-1 cannot wrap
  assign w_terminal = (r_cuenta == r_periodo - WIDTH'(1));

  always_comb begin
    w_estado_nxt = r_estado;
    w_cuenta_nxt = r_cuenta;
    w_fin_nxt    = 1'b0;
    w_cargar     = 1'b0;
    if (parar) begin
      w_estado_nxt = ST_IDLE;
      w_cuenta_nxt = '0;
    end else begin
      case (r_estado)
        ST_IDLE: begin
          w_cuenta_nxt = '0;
          if (inicio && (tiempo != '0)) begin
            w_cargar     = 1'b1;
            w_estado_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (!pausa) begin
            if (w_terminal) begin
              w_fin_nxt    = 1'b1;
              w_cuenta_nxt = '0;
              if (r_modo != MODO_CONT) w_estado_nxt = ST_IDLE;
            end else begin
              w_cuenta_nxt = r_cuenta + WIDTH'(1);
            end
          end
        end
        default: w_estado_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_estado  <= ST_IDLE;
      r_cuenta  <= '0;
      r_periodo <= '0;
      r_modo    <= MODO_UNICO;
      r_fin     <= 1'b0;
    end else begin
      r_estado <= w_estado_nxt;
      r_cuenta <= w_cuenta_nxt;
      r_fin    <= w_fin_nxt;
      if (w_cargar) begin
        r_periodo <= tiempo;
        r_modo    <= modo;
      end
    end
  end

  assign cuenta  = r_cuenta;
  assign fin     = r_fin;
  assign ocupado = (r_estado == ST_RUN);

endmodule

// File: tb/tb_contador_rtc_prog.sv
// tb/tb_contador_rtc_prog.sv - directed self-checking bench for contador_rtc_prog
module tb_contador_rtc_prog;

  logic       clk;
  logic       reset;
  logic       inicio;
  logic       parar;
  logic       pausa;
  logic       modo;
  logic [7:0] tiempo;
  logic [7:0] cuenta;
  logic       fin;
  logic       ocupado;

  int n_pass;
  int n_total;

  contador_rtc_prog #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .inicio(inicio), .parar(parar), .pausa(pausa),
    .modo(modo), .tiempo(tiempo), .cuenta(cuenta), .fin(fin), .ocupado(ocupado)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", name, got, exp);
    else n_pass++;
  endtask

  task automatic start(input logic [7:0] t, input logic m);
    tiempo = t; modo = m; inicio = 1'b1;
    tick();
    inicio = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      inicio = 1'($urandom); parar = 1'($urandom); pausa = 1'($urandom);
      modo = 1'($urandom); tiempo = 8'($urandom);
      tick();
      n_total++;
      if (cuenta !== 8'd0 || fin !== 1'b0 || ocupado !== 1'b0)
        $display("FAIL reset_hold: got cuenta=%0d fin=%0d ocupado=%0d expected 0/0/0", cuenta, fin, ocupado);
      else n_pass++;
    end
    inicio = 0; parar = 0; pausa = 0; modo = 0; tiempo = 0;
    reset = 1'b1;
    tick(); tick();
    n_total++;
    if (ocupado !== 1'b0 || cuenta !== 8'd0 || fin !== 1'b0)
      $display("FAIL reset_release: got ocupado=%0d cuenta=%0d fin=%0d expected 0/0/0", ocupado, cuenta, fin);
    else n_pass++;
  endtask

  task automatic test_one_shot();
    start(8'd5, 1'b0);
    n_total++;
    if (ocupado !== 1'b1 || cuenta !== 8'd0 || fin !== 1'b0)
      $display("FAIL oneshot_start: got ocupado=%0d cuenta=%0d fin=%0d expected 1/0/0", ocupado, cuenta, fin);
    else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_total++;
      if (cuenta !== 8'(i) || fin !== 1'b0)
        $display("FAIL oneshot_count: got cuenta=%0d fin=%0d expected %0d/0", cuenta, fin, i);
      else n_pass++;
    end
    tick();
    n_total++;
    if (fin !== 1'b1 || cuenta !== 8'd0 || ocupado !== 1'b0)
      $display("FAIL oneshot_fin: got fin=%0d cuenta=%0d ocupado=%0d expected 1/0/0", fin, cuenta, ocupado);
    else n_pass++;
    tick();
    chk("oneshot_fin_single", fin, 0);
  endtask

  task automatic test_continuous();
    int fins;
    fins = 0;
    start(8'd3, 1'b1);
    tiempo = 8'd7;
    for (int t = 1; t <= 12; t++) begin
      tick();
      if (fin === 1'b1) fins++;
      n_total++;
      if (fin !== ((t % 3) == 0) || cuenta !== 8'(t % 3) || ocupado !== 1'b1)
        $display("FAIL cont_step: t=%0d got fin=%0d cuenta=%0d ocupado=%0d expected %0d/%0d/1",
                 t, fin, cuenta, ocupado, ((t % 3) == 0), t % 3);
      else n_pass++;
    end
    chk("cont_fin_count", fins, 4);
    parar = 1'b1; tick(); parar = 1'b0;
    chk("cont_parar_idle", ocupado, 0);
  endtask

  task automatic test_edge_periods();
    start(8'd0, 1'b1);
    n_total++;
    if (ocupado !== 1'b0 || fin !== 1'b0)
      $display("FAIL p0_ignored: got ocupado=%0d fin=%0d expected 0/0", ocupado, fin);
    else n_pass++;
    tick();
    chk("p0_no_fin", fin, 0);

    start(8'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_total++;
      if (fin !== 1'b1 || cuenta !== 8'd0 || ocupado !== 1'b1)
        $display("FAIL p1_cont: got fin=%0d cuenta=%0d ocupado=%0d expected 1/0/1", fin, cuenta, ocupado);
      else n_pass++;
    end
    parar = 1'b1; tick(); parar = 1'b0;

    start(8'd1, 1'b0);
    tick();
    n_total++;
    if (fin !== 1'b1 || ocupado !== 1'b0)
      $display("FAIL p1_oneshot: got fin=%0d ocupado=%0d expected 1/0", fin, ocupado);
    else n_pass++;
    tick();
    chk("p1_oneshot_single", fin, 0);

    start(8'd255, 1'b0);
    for (int i = 1; i <= 254; i++) begin
      tick();
      if (fin !== 1'b0 || cuenta !== 8'(i)) begin
        n_total++;
        $display("FAIL p255_count: i=%0d got cuenta=%0d fin=%0d expected %0d/0", i, cuenta, fin, i);
      end
    end
    tick();
    n_total++;
    if (fin !== 1'b1 || cuenta !== 8'd0 || ocupado !== 1'b0)
      $display("FAIL p255_fin: got fin=%0d cuenta=%0d ocupado=%0d expected 1/0/0", fin, cuenta, ocupado);
    else n_pass++;
  endtask

  task automatic test_pause();
    int edges;
    edges = 0;
    start(8'd6, 1'b0);
    tick(); tick();
    chk("pause_at2", cuenta, 2);
    pausa = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      n_total++;
      if (cuenta !== 8'd2 || fin !== 1'b0)
        $display("FAIL pause_hold: got cuenta=%0d fin=%0d expected 2/0", cuenta, fin);
      else n_pass++;
    end
    pausa = 1'b0;
    while (fin !== 1'b1 && edges < 20) begin
      tick();
      edges++;
    end
    chk("pause_fin_delay", edges + 6, 10);
  endtask

  task automatic test_parar();
    start(8'd6, 1'b0);
    tick(); tick(); tick();
    chk("parar_at3", cuenta, 3);
    parar = 1'b1; tick(); parar = 1'b0;
    n_total++;
    if (ocupado !== 1'b0 || cuenta !== 8'd0 || fin !== 1'b0)
      $display("FAIL parar_abort: got ocupado=%0d cuenta=%0d fin=%0d expected 0/0/0", ocupado, cuenta, fin);
    else n_pass++;
    tiempo = 8'd4; inicio = 1'b1; parar = 1'b1;
    tick();
    inicio = 1'b0; parar = 1'b0;
    chk("parar_with_inicio", ocupado, 0);
    tick();
    chk("parar_with_inicio_after", ocupado, 0);
  endtask

  task automatic test_back_to_back();
    start(8'd2, 1'b0);
    tick();
    chk("b2b_count1", cuenta, 1);
    inicio = 1'b1;
    tick();
    n_total++;
    if (fin !== 1'b1 || ocupado !== 1'b0)
      $display("FAIL b2b_first_fin: got fin=%0d ocupado=%0d expected 1/0", fin, ocupado);
    else n_pass++;
    tick();
    inicio = 1'b0;
    n_total++;
    if (ocupado !== 1'b1 || cuenta !== 8'd0 || fin !== 1'b0)
      $display("FAIL b2b_restart: got ocupado=%0d cuenta=%0d fin=%0d expected 1/0/0", ocupado, cuenta, fin);
    else n_pass++;
    tick(); tick();
    chk("b2b_second_fin", fin, 1);
  endtask

  task automatic test_async_reset();
    start(8'd10, 1'b0);
    tick(); tick(); tick(); tick();
    chk("areset_at4", cuenta, 4);
    #2 reset = 1'b0;
    #1;
    n_total++;
    if (cuenta !== 8'd0 || fin !== 1'b0 || ocupado !== 1'b0)
      $display("FAIL areset_immediate: got cuenta=%0d fin=%0d ocupado=%0d expected 0/0/0", cuenta, fin, ocupado);
    else n_pass++;
    tick();
    chk("areset_no_fin", fin, 0);
    #2 reset = 1'b1;
    tick();
    start(8'd3, 1'b0);
    n_total++;
    if (ocupado !== 1'b1 || cuenta !== 8'd0)
      $display("FAIL areset_restart: got ocupado=%0d cuenta=%0d expected 1/0", ocupado, cuenta);
    else n_pass++;
    tick(); tick(); tick();
    chk("areset_restart_fin", fin, 1);
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset = 1'b0; inicio = 0; parar = 0; pausa = 0; modo = 0; tiempo = 0;
    test_reset();
    test_one_shot();
    test_continuous();
    test_edge_periods();
    test_pause();
    test_parar();
    test_back_to_back();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
